// File: rtl/spectro_pkg.sv
// Shared framing definitions for the channel-scan serial link.
// The scan sequencer and the frame receiver both import this package so
// word width, slot count and slot numbering stay in lock-step.
package spectro_pkg;

    localparam int WORD_W  = 12;  // bits per slot word
    localparam int N_SLOTS = 16;  // RTC + 15 channels
    localparam int SLOT_W  = 4;   // slot index width
    localparam int SCNT_W  = 5;   // words-in-frame counter, holds 0..N_SLOTS

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_BOUND = 2'd2
    } rx_state_t;

    localparam logic [SLOT_W-1:0] SLOT_RTC  = 4'd0;
    localparam logic [SLOT_W-1:0] SLOT_CH1  = 4'd1;
    localparam logic [SLOT_W-1:0] SLOT_CH2  = 4'd2;
    localparam logic [SLOT_W-1:0] SLOT_CH3  = 4'd3;
    localparam logic [SLOT_W-1:0] SLOT_CH4  = 4'd4;
    localparam logic [SLOT_W-1:0] SLOT_CH5  = 4'd5;
    localparam logic [SLOT_W-1:0] SLOT_CH6  = 4'd6;
    localparam logic [SLOT_W-1:0] SLOT_CH7  = 4'd7;
    localparam logic [SLOT_W-1:0] SLOT_CH8  = 4'd8;
    localparam logic [SLOT_W-1:0] SLOT_CH9  = 4'd9;
    localparam logic [SLOT_W-1:0] SLOT_CH10 = 4'd10;
    localparam logic [SLOT_W-1:0] SLOT_CH11 = 4'd11;
    localparam logic [SLOT_W-1:0] SLOT_CH12 = 4'd12;
    localparam logic [SLOT_W-1:0] SLOT_CH13 = 4'd13;
    localparam logic [SLOT_W-1:0] SLOT_CH14 = 4'd14;
    localparam logic [SLOT_W-1:0] SLOT_CH15 = 4'd15;

endpackage

// File: rtl/spectro_frame_buf.sv
// Double frame buffer: a work bank filled word by word while a frame is
// received, and a read bank holding the last complete frame.
// Ports:
//   clk, reset          clock, synchronous active-high reset (clears both banks)
//   wr_en/wr_addr/wr_data  indexed write into the work bank
//   commit              copy the whole work bank into the read bank in one cycle
//   rd_addr/rd_data     registered read of the read bank, 1-cycle latency
module spectro_frame_buf
    import spectro_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [SLOT_W-1:0] wr_addr,
    input  logic [WORD_W-1:0] wr_data,
    input  logic              commit,
    input  logic [SLOT_W-1:0] rd_addr,
    output logic [WORD_W-1:0] rd_data
);

    logic [WORD_W-1:0] work_bank [N_SLOTS];
    logic [WORD_W-1:0] read_bank [N_SLOTS];

    // rd_data samples the read bank before a same-cycle commit lands, so the
    // new frame shows up one cycle after the commit cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N_SLOTS; i++) begin
                work_bank[i] <= '0;
                read_bank[i] <= '0;
            end
            rd_data <= '0;
        end else begin
            if (wr_en) begin
                work_bank[wr_addr] <= wr_data;
            end
            if (commit) begin
                for (int i = 0; i < N_SLOTS; i++) begin
                    read_bank[i] <= work_bank[i];
                end
            end
            rd_data <= read_bank[rd_addr];
        end
    end

endmodule

// File: rtl/spectro_frame_rx.sv
// Receive end of the channel-scan serial link: deserializes 12-bit slot
// words (MSB first, sl on the MSB), checks framing against the fe strobe,
// and commits complete 16-word frames to a readable bank.
// Ports:
//   clk, reset                    clock, synchronous active-high reset
//   sdata, sl, fe                 serial bit, slot-load strobe, frame-end strobe
//   word_data/word_slot/word_valid  last received word and its slot, 1-cycle pulse
//   frame_valid, frame_cnt        commit pulse and wrapping committed-frame count
//   err_sync, err_len, err_clr    sticky framing / length errors and their clear
//   rd_addr, rd_data              registered read of the committed frame
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | no frame in progress, waiting for sl
// ST_SHIFT | shifting bits of a word, bit_cnt = bits already taken
// ST_BOUND | word just completed (word_valid high); expect sl, or fe after 16
module spectro_frame_rx
    import spectro_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              sdata,
    input  logic              sl,
    input  logic              fe,
    output logic [WORD_W-1:0] word_data,
    output logic [SLOT_W-1:0] word_slot,
    output logic              word_valid,
    output logic              frame_valid,
    output logic [7:0]        frame_cnt,
    output logic              err_sync,
    output logic              err_len,
    input  logic              err_clr,
    input  logic [SLOT_W-1:0] rd_addr,
    output logic [WORD_W-1:0] rd_data
);

    rx_state_t         state, state_n;
    logic [3:0]        bit_cnt;
    logic [SCNT_W-1:0] slot_cnt;
    logic [WORD_W-2:0] shreg;

    logic start_word, shift_bit, word_done, commit;
    logic discard, set_sync, set_len;
    logic frame_full, last_bit;

    assign frame_full = (slot_cnt == SCNT_W'(N_SLOTS));
    assign last_bit   = (bit_cnt == 4'(WORD_W - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        if (fe) begin
            state_n = ST_IDLE;
        end else begin
            unique case (state)
                ST_IDLE:  if (sl) state_n = ST_SHIFT;
                ST_SHIFT: if (!sl && last_bit) state_n = ST_BOUND;
                ST_BOUND: state_n = sl ? ST_SHIFT : ST_IDLE;
                default:  state_n = ST_IDLE;
            endcase
        end
    end

    // Action decode. fe always wins over sl; sl together with fe only flags
    // err_sync on top of whatever fe does.
    always_comb begin
        start_word = 1'b0;
        shift_bit  = 1'b0;
        word_done  = 1'b0;
        commit     = 1'b0;
        discard    = 1'b0;
        set_sync   = 1'b0;
        set_len    = 1'b0;
        if (fe) begin
            set_sync = sl;
            if (state == ST_BOUND && frame_full) begin
                commit = 1'b1;
            end else begin
                set_len = 1'b1;
                discard = 1'b1;
            end
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (sl) begin
                        start_word = 1'b1;
                        discard    = 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (sl) begin
                        set_sync   = 1'b1;
                        discard    = 1'b1;
                        start_word = 1'b1;
                    end else if (last_bit) begin
                        word_done = 1'b1;
                    end else begin
                        shift_bit = 1'b1;
                    end
                end
                ST_BOUND: begin
                    if (sl) begin
                        start_word = 1'b1;
                        if (frame_full) begin
                            set_len = 1'b1;
                            discard = 1'b1;
                        end
                    end else begin
                        set_sync = 1'b1;
                        discard  = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bit_cnt     <= '0;
            slot_cnt    <= '0;
            shreg       <= '0;
            word_data   <= '0;
            word_slot   <= '0;
            word_valid  <= 1'b0;
            frame_valid <= 1'b0;
            frame_cnt   <= '0;
            err_sync    <= 1'b0;
            err_len     <= 1'b0;
        end else begin
            word_valid  <= word_done;
            frame_valid <= commit;
            if (commit) begin
                frame_cnt <= frame_cnt + 8'd1;
            end
            // A fresh error in the err_clr cycle keeps the flag set.
            err_sync <= set_sync | (err_sync & ~err_clr);
            err_len  <= set_len  | (err_len  & ~err_clr);

            if (discard || commit) begin
                slot_cnt <= '0;
            end

            if (start_word) begin
                shreg   <= {shreg[WORD_W-3:0], sdata};
                bit_cnt <= 4'd1;
            end else if (shift_bit) begin
                shreg   <= {shreg[WORD_W-3:0], sdata};
                bit_cnt <= bit_cnt + 4'd1;
            end else if (word_done) begin
                shreg     <= {shreg[WORD_W-3:0], sdata};
                bit_cnt   <= '0;
                word_data <= {shreg, sdata};
                word_slot <= slot_cnt[SLOT_W-1:0];
                slot_cnt  <= slot_cnt + SCNT_W'(1);
            end else begin
                bit_cnt <= '0;
            end
        end
    end

    spectro_frame_buf u_buf (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (word_done),
        .wr_addr (slot_cnt[SLOT_W-1:0]),
        .wr_data ({shreg, sdata}),
        .commit  (commit),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

endmodule

// File: tb/tb_spectro_frame_rx.sv
module tb_spectro_frame_rx;
    import spectro_pkg::*;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              sdata = 1'b0;
    logic              sl = 1'b0;
    logic              fe = 1'b0;
    logic              err_clr = 1'b0;
    logic [SLOT_W-1:0] rd_addr = '0;
    logic [WORD_W-1:0] word_data;
    logic [SLOT_W-1:0] word_slot;
    logic              word_valid;
    logic              frame_valid;
    logic [7:0]        frame_cnt;
    logic              err_sync;
    logic              err_len;
    logic [WORD_W-1:0] rd_data;

    always #5 clk = ~clk;

    spectro_frame_rx dut (
        .clk         (clk),
        .reset       (reset),
        .sdata       (sdata),
        .sl          (sl),
        .fe          (fe),
        .word_data   (word_data),
        .word_slot   (word_slot),
        .word_valid  (word_valid),
        .frame_valid (frame_valid),
        .frame_cnt   (frame_cnt),
        .err_sync    (err_sync),
        .err_len     (err_len),
        .err_clr     (err_clr),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data)
    );

    int checks = 0;
    int errors = 0;
    int rd_pin = -1;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: tracks the frame as a list of received words and the
    // word currently being assembled, and applies the framing rules directly.
    logic              started = 1'b0;
    logic [WORD_W-1:0] m_rbank [N_SLOTS];
    logic [WORD_W-1:0] m_frame [$];
    bit                m_in_word = 0;
    bit                m_boundary = 0;
    int                m_nbits = 0;
    int                m_acc = 0;
    logic [WORD_W-1:0] e_wd = '0;
    logic [SLOT_W-1:0] e_ws = '0;
    logic              e_wv = 0, e_fv = 0, e_sync = 0, e_len = 0;
    logic [7:0]        e_fcnt = '0;
    logic [WORD_W-1:0] e_rd = '0;

    always @(posedge clk) begin : model
        bit new_sync, new_len;
        if (reset) begin
            started = 1'b1;
            for (int i = 0; i < N_SLOTS; i++) m_rbank[i] = '0;
            m_frame.delete();
            m_in_word = 0; m_boundary = 0; m_nbits = 0; m_acc = 0;
            e_wd = '0; e_ws = '0; e_wv = 0; e_fv = 0;
            e_fcnt = '0; e_sync = 0; e_len = 0; e_rd = '0;
        end else begin
            new_sync = 0; new_len = 0;
            e_rd = m_rbank[rd_addr];
            e_wv = 0; e_fv = 0;
            if (fe) begin
                new_sync = sl;
                if (m_boundary && m_frame.size() == N_SLOTS) begin
                    for (int i = 0; i < N_SLOTS; i++) m_rbank[i] = m_frame[i];
                    e_fcnt = e_fcnt + 8'd1;
                    e_fv = 1;
                end else begin
                    new_len = 1;
                end
                m_frame.delete();
                m_in_word = 0; m_boundary = 0;
            end else if (sl) begin
                if (m_in_word) begin
                    new_sync = 1;
                    m_frame.delete();
                end else if (m_boundary) begin
                    if (m_frame.size() == N_SLOTS) begin
                        new_len = 1;
                        m_frame.delete();
                    end
                end else begin
                    m_frame.delete();
                end
                m_in_word = 1; m_boundary = 0;
                m_nbits = 1; m_acc = int'(sdata);
            end else if (m_in_word) begin
                m_acc = m_acc * 2 + int'(sdata);
                m_nbits++;
                if (m_nbits == WORD_W) begin
                    e_wd = WORD_W'(m_acc);
                    e_ws = SLOT_W'(m_frame.size());
                    m_frame.push_back(WORD_W'(m_acc));
                    e_wv = 1;
                    m_in_word = 0; m_boundary = 1;
                end
            end else if (m_boundary) begin
                new_sync = 1;
                m_frame.delete();
                m_boundary = 0;
            end
            e_sync = new_sync | (e_sync & ~err_clr);
            e_len  = new_len  | (e_len  & ~err_clr);
        end
    end

    always @(negedge clk) begin
        if (started) begin
            cmp("word_valid",  32'(word_valid),  32'(e_wv));
            cmp("word_data",   32'(word_data),   32'(e_wd));
            cmp("word_slot",   32'(word_slot),   32'(e_ws));
            cmp("frame_valid", 32'(frame_valid), 32'(e_fv));
            cmp("frame_cnt",   32'(frame_cnt),   32'(e_fcnt));
            cmp("err_sync",    32'(err_sync),    32'(e_sync));
            cmp("err_len",     32'(err_len),     32'(e_len));
            cmp("rd_data",     32'(rd_data),     32'(e_rd));
        end
    end

    logic [WORD_W-1:0] fw [N_SLOTS];

    task automatic drive(input logic s, input logic f, input logic d,
                         input logic clr = 1'b0, input logic rst = 1'b0);
        @(negedge clk);
        sl = s; fe = f; sdata = d; err_clr = clr; reset = rst;
        rd_addr = (rd_pin < 0) ? SLOT_W'($urandom) : SLOT_W'(rd_pin);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, 1'($urandom));
    endtask

    task automatic send_bits(input logic [WORD_W-1:0] w, input int nbits);
        for (int i = 0; i < nbits; i++) drive(i == 0, 1'b0, w[WORD_W-1-i]);
    endtask

    task automatic send_body(input int nwords);
        for (int k = 0; k < nwords; k++) send_bits(fw[k], WORD_W);
    endtask

    task automatic fill_random();
        for (int k = 0; k < N_SLOTS; k++) fw[k] = WORD_W'($urandom);
    endtask

    initial begin
        drive(0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 1);
        cmp("reset_frame_cnt", 32'(frame_cnt), 0);
        cmp("reset_rd_data", 32'(rd_data), 0);
        cmp("reset_errs", 32'({err_sync, err_len}), 0);

        // nominal frame, slot k = 0xA50 ^ k
        for (int k = 0; k < N_SLOTS; k++) fw[k] = 12'hA50 ^ WORD_W'(k);
        send_body(N_SLOTS);
        rd_pin = 3;
        drive(0, 1, 0);
        idle(1);
        cmp("nom_frame_valid", 32'(frame_valid), 1);
        cmp("nom_frame_cnt", 32'(frame_cnt), 1);
        idle(1);
        cmp("nom_rd3", 32'(rd_data), 32'h0A53);

        // short frame: fe after 10 words
        rd_pin = 0;
        send_body(10);
        drive(0, 1, 0);
        idle(2);
        cmp("short_err_len", 32'(err_len), 1);
        cmp("short_frame_cnt", 32'(frame_cnt), 1);
        cmp("short_rd0_kept", 32'(rd_data), 32'h0A50);
        drive(0, 0, 0, 1);
        idle(1);
        cmp("clr_err_len", 32'(err_len), 0);

        // sl at bit 5 of slot 2; the restart begins a clean 0x123 frame
        send_body(2);
        send_bits(fw[2], 5);
        for (int k = 0; k < N_SLOTS; k++) fw[k] = 12'h123;
        send_body(N_SLOTS);
        rd_pin = 7;
        drive(0, 1, 0);
        idle(2);
        cmp("sync_err_sync", 32'(err_sync), 1);
        cmp("sync_frame_cnt", 32'(frame_cnt), 2);
        cmp("sync_rd7", 32'(rd_data), 32'h0123);
        idle(3);
        cmp("sync_sticky", 32'(err_sync), 1);
        drive(0, 0, 0, 1);
        idle(1);
        cmp("sync_cleared", 32'(err_sync), 0);

        // reset in the middle of slot 7
        rd_pin = -1;
        fill_random();
        send_body(7);
        send_bits(fw[7], 4);
        drive(0, 0, 0, 0, 1);
        idle(1);
        cmp("mid_rst_frame_cnt", 32'(frame_cnt), 0);
        cmp("mid_rst_rd", 32'(rd_data), 0);
        cmp("mid_rst_errs", 32'({err_sync, err_len}), 0);
        cmp("mid_rst_word_valid", 32'(word_valid), 0);
        fill_random();
        send_body(N_SLOTS);
        rd_pin = 5;
        drive(0, 1, 0);
        idle(1);
        cmp("post_rst_frame_cnt", 32'(frame_cnt), 1);
        idle(1);
        cmp("post_rst_rd5", 32'(rd_data), 32'(fw[5]));

        // sl and fe together after 16 words
        rd_pin = -1;
        fill_random();
        send_body(N_SLOTS);
        drive(1, 1, 1);
        idle(1);
        cmp("slfe_frame_valid", 32'(frame_valid), 1);
        cmp("slfe_err_sync", 32'(err_sync), 1);
        cmp("slfe_err_len", 32'(err_len), 0);
        cmp("slfe_frame_cnt", 32'(frame_cnt), 2);
        idle(13);
        cmp("slfe_no_word", 32'(word_valid), 0);

        // randomized frames with occasional framing faults
        for (int f = 0; f < 30; f++) begin
            int mode, n;
            fill_random();
            mode = $urandom_range(0, 7);
            if (mode == 0) begin
                n = $urandom_range(1, 15);
                send_body(n);
                drive(0, 1, 0);
            end else if (mode == 1) begin
                n = $urandom_range(1, 15);
                send_body(n);
                idle(1);
                for (int k = n; k < N_SLOTS; k++) send_bits(fw[k], WORD_W);
                drive(0, 1, 0);
            end else if (mode == 2) begin
                send_body(N_SLOTS);
                send_bits(fw[0], WORD_W);
                drive(0, 1, 0);
            end else if (mode == 3) begin
                n = $urandom_range(0, 15);
                send_body(n);
                send_bits(fw[n], $urandom_range(1, 11));
                send_body(N_SLOTS);
                drive(0, 1, 0);
            end else begin
                send_body(N_SLOTS);
                drive(0, 1, 0);
            end
            idle($urandom_range(0, 2));
            if ($urandom_range(0, 3) == 0) drive(0, 0, 1'($urandom), 1);
        end

        // 256 back-to-back frames from reset: counter wraps to 0
        drive(0, 0, 0, 0, 1);
        for (int f = 0; f < 256; f++) begin
            fill_random();
            send_body(N_SLOTS);
            drive(0, 1, 0);
        end
        idle(2);
        cmp("wrap_frame_cnt", 32'(frame_cnt), 0);
        cmp("wrap_errs", 32'({err_sync, err_len}), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
